// File: rtl/cu_pipe_pkg.sv
// Shared definitions for the cu_pipe control unit: opcodes, ALU codes,
// immediate/result-source encodings and the per-stage control bundles.
// Optional feature macro: CU_PIPE_JUMP_EN (adds jal/jalr decode and the
// jump_reg field of the E bundle).
package cu_pipe_pkg;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Native width of the ALU code before zero-extension at the top
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Write-back result sources
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // Branch funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // W bundle: what survives to register write-back
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  // M bundle: the store enable is only consumed in the first M slot
  typedef struct packed {
    logic    mem_write;
    ctrl_w_t wb;
  } ctrl_m_t;

  // E bundle: everything the execute stage needs plus the later stages
  typedef struct packed {
    ctrl_m_t    mem;
    logic       branch;
    logic       jump;
`ifdef CU_PIPE_JUMP_EN
    logic       jump_reg;
`endif
    logic       alu_src_b;
    alu_op_e    alu_ctl;
    logic [2:0] funct3;
  } ctrl_e_t;

  // ALU operation for R-type and I-type ALU instructions. SUB only exists
  // for R-type; I-type funct7 bit 5 is immediate data except on shifts.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3,
                                             input logic       is_rtype,
                                             input logic       f7b5);
    alu_op_e op;
    case (f3)
      3'b000: begin
        if (is_rtype && f7b5) op = ALU_SUB;
        else                  op = ALU_ADD;
      end
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: begin
        if (f7b5) op = ALU_SRA;
        else      op = ALU_SRL;
      end
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cu_pipe_decode.sv
// cu_decode: combinational main decoder and ALU decoder for the D stage.
// Illegal encodings produce an all-zero control bundle so that nothing
// downstream writes or redirects. Optional feature macro: CU_PIPE_JUMP_EN
// (jal/jalr are decoded only when it is defined).
module cu_decode
  import cu_pipe_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ctrl_e_t    ctrl_o,
  output logic [2:0] imm_src_o,
  output logic       illegal_o
);

  ctrl_e_t    raw_ctrl;
  logic [2:0] raw_imm;
  logic       bad_enc;

  // Main decoder: classify the opcode and flag unrecognised funct fields
  always_comb begin
    raw_ctrl        = '0;
    raw_imm         = IMM_I;
    bad_enc         = 1'b0;
    raw_ctrl.funct3 = funct3_i;
    case (op_i)
      OP_RTYPE: begin
        raw_ctrl.mem.wb.reg_write  = 1'b1;
        raw_ctrl.mem.wb.result_src = RES_ALU;
        raw_ctrl.alu_ctl           = alu_from_funct(funct3_i, 1'b1, funct7b5_i);
        bad_enc = funct7b5_i && (funct3_i != 3'b000) && (funct3_i != 3'b101);
      end
      OP_ITYPE: begin
        raw_ctrl.mem.wb.reg_write  = 1'b1;
        raw_ctrl.mem.wb.result_src = RES_ALU;
        raw_ctrl.alu_src_b         = 1'b1;
        raw_ctrl.alu_ctl           = alu_from_funct(funct3_i, 1'b0, funct7b5_i);
        bad_enc = funct7b5_i && (funct3_i == 3'b001);
      end
      OP_LOAD: begin
        raw_ctrl.mem.wb.reg_write  = 1'b1;
        raw_ctrl.mem.wb.result_src = RES_MEM;
        raw_ctrl.alu_src_b         = 1'b1;
        raw_ctrl.alu_ctl           = ALU_ADD;
        bad_enc = (funct3_i != 3'b010);
      end
      OP_STORE: begin
        raw_ctrl.mem.mem_write = 1'b1;
        raw_ctrl.alu_src_b     = 1'b1;
        raw_ctrl.alu_ctl       = ALU_ADD;
        raw_imm                = IMM_S;
        bad_enc = (funct3_i != 3'b010);
      end
      OP_BRANCH: begin
        raw_ctrl.branch  = 1'b1;
        raw_ctrl.alu_ctl = ALU_SUB;
        raw_imm          = IMM_B;
        bad_enc = (funct3_i == 3'b010) || (funct3_i == 3'b011);
      end
      OP_LUI: begin
        raw_ctrl.mem.wb.reg_write  = 1'b1;
        raw_ctrl.mem.wb.result_src = RES_IMM;
        raw_ctrl.alu_src_b         = 1'b1;
        raw_ctrl.alu_ctl           = ALU_ADD;
        raw_imm                    = IMM_U;
      end
`ifdef CU_PIPE_JUMP_EN
      OP_JAL: begin
        raw_ctrl.mem.wb.reg_write  = 1'b1;
        raw_ctrl.mem.wb.result_src = RES_PC4;
        raw_ctrl.jump              = 1'b1;
        raw_ctrl.alu_ctl           = ALU_ADD;
        raw_imm                    = IMM_J;
      end
      OP_JALR: begin
        raw_ctrl.mem.wb.reg_write  = 1'b1;
        raw_ctrl.mem.wb.result_src = RES_PC4;
        raw_ctrl.jump              = 1'b1;
        raw_ctrl.jump_reg          = 1'b1;
        raw_ctrl.alu_src_b         = 1'b1;
        raw_ctrl.alu_ctl           = ALU_ADD;
        bad_enc = (funct3_i != 3'b000);
      end
`endif
      default: bad_enc = 1'b1;
    endcase
  end

  // Squash illegal encodings so they carry no side effects into E
  always_comb begin
    ctrl_o    = bad_enc ? '0 : raw_ctrl;
    imm_src_o = bad_enc ? IMM_I : raw_imm;
    illegal_o = bad_enc;
  end

endmodule

// File: rtl/cu_pipe.sv
// cu_pipe: pipelined control unit. Decode is combinational in D; this module
// holds the D->E register, the MEM_STAGES-deep M slot chain, the W register
// and the branch resolution in E.
// Optional feature macro: CU_PIPE_JUMP_EN (jal/jalr support; otherwise
// JumpRegE is tied low and both opcodes decode as illegal).
module cu_pipe
  import cu_pipe_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int ALUCTL_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [6:0]          opD,
  input  logic [2:0]          funct3D,
  input  logic                funct7b5D,
  input  logic                FlushE,
  input  logic                ZeroE,
  input  logic                LtE,
  input  logic                LtuE,
  output logic [2:0]          ImmSrcD,
  output logic                IllegalD,
  output logic                PCSrcE,
  output logic                JumpRegE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                ALUSrcBE,
  output logic                ResultSrcEb0,
  output logic                MemWriteM,
  output logic                RegWriteM,
  output logic                RegWriteW,
  output logic [1:0]          ResultSrcW
);

  ctrl_e_t dec_ctrl;
  ctrl_e_t e_d;
  ctrl_e_t e_q;
  ctrl_m_t m_head_q;
  ctrl_w_t m_last;
  ctrl_w_t w_q;
  logic    br_taken;

  cu_decode u_decode (
    .op_i       (opD),
    .funct3_i   (funct3D),
    .funct7b5_i (funct7b5D),
    .ctrl_o     (dec_ctrl),
    .imm_src_o  (ImmSrcD),
    .illegal_o  (IllegalD)
  );

  // A flush turns the instruction entering E into a bubble
  always_comb begin
    e_d = FlushE ? '0 : dec_ctrl;
  end

  // E register; reset takes priority over the flush bubble
  always_ff @(posedge clock) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  // First M slot: the only place the store enable is needed
  always_ff @(posedge clock) begin
    if (reset) m_head_q <= '0;
    else       m_head_q <= e_q.mem;
  end

  // Remaining M slots only carry the write-back bundle towards W
  generate
    if (MEM_STAGES == 1) begin : g_single_slot
      assign m_last = m_head_q.wb;
    end else begin : g_slot_chain
      for (genvar gi = 0; gi < MEM_STAGES - 1; gi++) begin : g_slot
        ctrl_w_t slot_d;
        ctrl_w_t slot_q;
        if (gi == 0) begin : g_src
          assign slot_d = m_head_q.wb;
        end else begin : g_src
          assign slot_d = g_slot[gi-1].slot_q;
        end
        // One M slot; cleared by reset so in-flight writes are dropped
        always_ff @(posedge clock) begin
          if (reset) slot_q <= '0;
          else       slot_q <= slot_d;
        end
      end
      assign m_last = g_slot[MEM_STAGES-2].slot_q;
    end
  endgenerate

  // W register
  always_ff @(posedge clock) begin
    if (reset) w_q <= '0;
    else       w_q <= m_last;
  end

  // Branch condition from the carried funct3 and the live ALU flags
  always_comb begin
    br_taken = 1'b0;
    case (e_q.funct3)
      F3_BEQ:  br_taken = ZeroE;
      F3_BNE:  br_taken = ~ZeroE;
      F3_BLT:  br_taken = LtE;
      F3_BGE:  br_taken = ~LtE;
      F3_BLTU: br_taken = LtuE;
      F3_BGEU: br_taken = ~LtuE;
      default: br_taken = 1'b0;
    endcase
  end

  // A zero E register has branch=jump=0, so bubbles never redirect
  assign PCSrcE = (e_q.branch & br_taken) | e_q.jump;

`ifdef CU_PIPE_JUMP_EN
  assign JumpRegE = e_q.jump_reg;
`else
  assign JumpRegE = 1'b0;
`endif

  assign ALUControlE  = ALUCTL_W'(e_q.alu_ctl);
  assign ALUSrcBE     = e_q.alu_src_b;
  assign ResultSrcEb0 = e_q.mem.wb.result_src[0];
  assign MemWriteM    = m_head_q.mem_write;
  assign RegWriteM    = m_head_q.wb.reg_write;
  assign RegWriteW    = w_q.reg_write;
  assign ResultSrcW   = w_q.result_src;

endmodule

// File: tb/tb_cu_pipe.sv
// Scoreboard bench for cu_pipe. Stimulus decodes each instruction by
// mnemonic and queues the expected response for every stage at the cycle it
// is due; a negedge monitor pops and compares. Two instances cover
// MEM_STAGES=1 and MEM_STAGES=3. Honours CU_PIPE_JUMP_EN like the design.
module tb_cu_pipe;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opD = 7'd0;
  logic [2:0] funct3D = 3'd0;
  logic       funct7b5D = 1'b0;
  logic       FlushE = 1'b0;
  logic       ZeroE = 1'b0;
  logic       LtE = 1'b0;
  logic       LtuE = 1'b0;

  logic [2:0] ImmSrcD, ImmSrcD_3;
  logic       IllegalD, IllegalD_3;
  logic       PCSrcE, PCSrcE_3, JumpRegE, JumpRegE_3;
  logic [3:0] ALUControlE, ALUControlE_3;
  logic       ALUSrcBE, ALUSrcBE_3, ResultSrcEb0, ResultSrcEb0_3;
  logic       MemWriteM, MemWriteM_3, RegWriteM, RegWriteM_3;
  logic       RegWriteW, RegWriteW_3;
  logic [1:0] ResultSrcW, ResultSrcW_3;

  cu_pipe #(.MEM_STAGES(1), .ALUCTL_W(4)) dut1 (
    .clock(clock), .reset(reset), .opD(opD), .funct3D(funct3D),
    .funct7b5D(funct7b5D), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE),
    .LtuE(LtuE), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .PCSrcE(PCSrcE),
    .JumpRegE(JumpRegE), .ALUControlE(ALUControlE), .ALUSrcBE(ALUSrcBE),
    .ResultSrcEb0(ResultSrcEb0), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  cu_pipe #(.MEM_STAGES(3), .ALUCTL_W(4)) dut3 (
    .clock(clock), .reset(reset), .opD(opD), .funct3D(funct3D),
    .funct7b5D(funct7b5D), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE),
    .LtuE(LtuE), .ImmSrcD(ImmSrcD_3), .IllegalD(IllegalD_3), .PCSrcE(PCSrcE_3),
    .JumpRegE(JumpRegE_3), .ALUControlE(ALUControlE_3), .ALUSrcBE(ALUSrcBE_3),
    .ResultSrcEb0(ResultSrcEb0_3), .MemWriteM(MemWriteM_3),
    .RegWriteM(RegWriteM_3), .RegWriteW(RegWriteW_3), .ResultSrcW(ResultSrcW_3)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011;
  localparam logic [6:0] LW_OP = 7'b0000011, SW_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011, LUI_OP = 7'b0110111;
  localparam logic [6:0] JAL_OP = 7'b1101111, JALR_OP = 7'b1100111;
  localparam logic [6:0] NOP_OP = 7'b0000000;

  // stage: 0=D outputs, 1=E, 2=first M slot, 3=W (1 slot), 4=W (3 slots)
  typedef struct {
    int         due;
    int         stage;
    string      mn;
    logic       rw, mw, jmp, jr, srcb, ill;
    logic [1:0] rs;
    logic [2:0] imm;
    int         alu;
  } exp_t;

  exp_t sb[$];
  exp_t ex[5];
  bit   got[5];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b1;

  function automatic exp_t blank();
    exp_t x;
    x.due = 0; x.stage = 0; x.mn = "";
    x.rw = 0; x.mw = 0; x.jmp = 0; x.jr = 0; x.srcb = 0; x.ill = 0;
    x.rs = 2'd0; x.imm = 3'd0; x.alu = 0;
    return x;
  endfunction

  function automatic string base_name(input logic [2:0] f3);
    case (f3)
      3'd0: return "add";  3'd1: return "sll";
      3'd2: return "slt";  3'd3: return "sltu";
      3'd4: return "xor";  3'd5: return "srl";
      3'd6: return "or";   default: return "and";
    endcase
  endfunction

  function automatic string br_name(input logic [2:0] f3);
    case (f3)
      3'd0: return "beq";  3'd1: return "bne";
      3'd4: return "blt";  3'd5: return "bge";
      3'd6: return "bltu"; 3'd7: return "bgeu";
      default: return "bad";
    endcase
  endfunction

  function automatic int alu_of(input string mn);
    case (mn)
      "add": return 0; "sub": return 1; "and": return 2; "or": return 3;
      "xor": return 4; "slt": return 5; "sltu": return 6; "sll": return 7;
      "srl": return 8; "sra": return 9;
      default: return 0;
    endcase
  endfunction

  // Reference decode: instruction -> mnemonic -> control expectations
  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7);
    exp_t  x = blank();
    string mn = "bad";
    string cls = "bad";
    case (op)
      R_OP: begin
        cls = "alu"; mn = base_name(f3);
        if (f7) mn = (f3 == 3'd0) ? "sub" : (f3 == 3'd5) ? "sra" : "bad";
      end
      I_OP: begin
        cls = "alui"; mn = base_name(f3);
        if (f7 && f3 == 3'd1) mn = "bad";
        if (f7 && f3 == 3'd5) mn = "sra";
      end
      LW_OP:  if (f3 == 3'd2) begin cls = "load";  mn = "lw"; end
      SW_OP:  if (f3 == 3'd2) begin cls = "store"; mn = "sw"; end
      BR_OP:  begin mn = br_name(f3); cls = "branch"; end
      LUI_OP: begin cls = "lui"; mn = "lui"; end
`ifdef CU_PIPE_JUMP_EN
      JAL_OP:  begin cls = "jal"; mn = "jal"; end
      JALR_OP: if (f3 == 3'd0) begin cls = "jalr"; mn = "jalr"; end
`endif
      default: ;
    endcase
    if (mn == "bad") cls = "bad";
    case (cls)
      "alu":    begin x.rw = 1; x.alu = alu_of(mn); end
      "alui":   begin x.rw = 1; x.srcb = 1; x.alu = alu_of(mn); end
      "load":   begin x.rw = 1; x.rs = 2'b01; x.srcb = 1; end
      "store":  begin x.mw = 1; x.srcb = 1; x.imm = 3'b001; end
      "branch": begin x.alu = 1; x.imm = 3'b010; end
      "lui":    begin x.rw = 1; x.rs = 2'b11; x.srcb = 1; x.imm = 3'b100; end
      "jal":    begin x.rw = 1; x.rs = 2'b10; x.jmp = 1; x.imm = 3'b011; end
      "jalr":   begin x.rw = 1; x.rs = 2'b10; x.jmp = 1; x.jr = 1; x.srcb = 1; end
      default:  begin x.ill = 1; mn = ""; end
    endcase
    x.mn = mn;
    return x;
  endfunction

  function automatic logic ref_pcsrc(input exp_t e, input logic z, input logic lt,
                                     input logic ltu);
    case (e.mn)
      "beq":  return z;
      "bne":  return !z;
      "blt":  return lt;
      "bge":  return !lt;
      "bltu": return ltu;
      "bgeu": return !ltu;
      default: return e.jmp;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, req);
  endtask

  // One cycle of stimulus plus the expectations it creates
  task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic fl, input logic z, input logic lt,
                      input logic ltu);
    exp_t d, c;
    @(posedge clock);
    #1;
    reset = rst; opD = op; funct3D = f3; funct7b5D = f7; FlushE = fl;
    ZeroE = z; LtE = lt; LtuE = ltu;
    d = ref_decode(op, f3, f7);
    c = d;
    d.stage = 0; d.due = cyc;
    sb.push_back(d);
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due > cyc) sb.delete(i);
    end else begin
      if (fl || c.ill) c = blank();
      c.stage = 1; c.due = cyc + 1; sb.push_back(c);
      c.stage = 2; c.due = cyc + 2; sb.push_back(c);
      c.stage = 3; c.due = cyc + 3; sb.push_back(c);
      c.stage = 4; c.due = cyc + 5; sb.push_back(c);
    end
  endtask

  task automatic nop(input logic rst);
    step(rst, NOP_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pop what is due this cycle (absent => zero) and compare
  always @(negedge clock) begin
    if (mon_en && cyc >= 1) begin
      for (int s = 0; s < 5; s++) begin got[s] = 1'b0; ex[s] = blank(); end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          ex[sb[i].stage] = sb[i]; got[sb[i].stage] = 1'b1; sb.delete(i);
        end else if (sb[i].due < cyc) begin
          n_total++;
          $display("FAIL stale_entry cyc=%0d stage=%0d due=%0d", cyc, sb[i].stage, sb[i].due);
          sb.delete(i);
        end
      end
      if (got[0]) begin
        chk("ImmSrcD", 32'(ImmSrcD), 32'(ex[0].imm));
        chk("IllegalD", 32'(IllegalD), 32'(ex[0].ill));
      end
      chk("PCSrcE", 32'(PCSrcE), 32'(ref_pcsrc(ex[1], ZeroE, LtE, LtuE)));
      chk("JumpRegE", 32'(JumpRegE), 32'(ex[1].jr));
      chk("ALUControlE", 32'(ALUControlE), 32'(ex[1].alu));
      chk("ALUSrcBE", 32'(ALUSrcBE), 32'(ex[1].srcb));
      chk("ResultSrcEb0", 32'(ResultSrcEb0), 32'(ex[1].rs[0]));
      chk("MemWriteM", 32'(MemWriteM), 32'(ex[2].mw));
      chk("RegWriteM", 32'(RegWriteM), 32'(ex[2].rw));
      chk("RegWriteW_ms1", 32'(RegWriteW), 32'(ex[3].rw));
      chk("ResultSrcW_ms1", 32'(ResultSrcW), 32'(ex[3].rs));
      chk("RegWriteW_ms3", 32'(RegWriteW_3), 32'(ex[4].rw));
      chk("ResultSrcW_ms3", 32'(ResultSrcW_3), 32'(ex[4].rs));
      chk("PCSrcE_ms3", 32'(PCSrcE_3), 32'(ref_pcsrc(ex[1], ZeroE, LtE, LtuE)));
    end
  end

  logic [6:0] op_tab [8];

  initial begin
    op_tab[0] = R_OP;  op_tab[1] = I_OP;   op_tab[2] = LW_OP;  op_tab[3] = SW_OP;
    op_tab[4] = BR_OP; op_tab[5] = LUI_OP; op_tab[6] = JAL_OP; op_tab[7] = JALR_OP;

    // Two reset cycles (cycle 0 from the initial value, then one more)
    nop(1'b1);
    // add, sub, sra
    step(0, R_OP, 3'b000, 0, 0, 0, 0, 0);
    step(0, R_OP, 3'b000, 1, 0, 0, 0, 0);
    step(0, R_OP, 3'b101, 1, 0, 0, 0, 0);
    // lw then sw
    step(0, LW_OP, 3'b010, 0, 0, 0, 0, 0);
    step(0, SW_OP, 3'b010, 0, 0, 0, 0, 0);
    // blt taken, blt not taken, flushed beq with Zero set
    step(0, BR_OP, 3'b100, 0, 0, 0, 0, 0);
    step(0, BR_OP, 3'b100, 0, 0, 0, 1, 0);
    step(0, NOP_OP, 3'b000, 0, 0, 0, 0, 0);
    step(0, BR_OP, 3'b000, 0, 1, 0, 0, 0);
    step(0, NOP_OP, 3'b000, 0, 0, 1, 0, 0);
    // jalr and jal (legal or illegal depending on the build)
    step(0, JALR_OP, 3'b000, 0, 0, 0, 0, 0);
    step(0, JAL_OP, 3'b000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) nop(1'b0);
    // lw, then reset three cycles later kills its write in the deep pipe
    step(0, LW_OP, 3'b010, 0, 0, 0, 0, 0);
    nop(1'b0);
    nop(1'b0);
    nop(1'b1);
    for (int i = 0; i < 4; i++) nop(1'b0);
    // Reset and flush together
    step(1, R_OP, 3'b000, 0, 1, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int         sel;
      sel = int'($urandom_range(0, 8));
      op  = (sel == 8) ? 7'($urandom_range(0, 127)) : op_tab[sel];
      f3  = 3'($urandom_range(0, 7));
      if ((op == LW_OP || op == SW_OP) && $urandom_range(0, 3) != 0) f3 = 3'b010;
      step(($urandom_range(0, 39) == 0), op, f3, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) nop(1'b0);
    @(posedge clock);
    mon_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cu_pipe.md
CU_PIPE -- requirements
Module: cu_pipe

Interface
REQ-001 Parameter MEM_STAGES, default 1, number of memory-stage register slots between the E and W stages (legal 1..3).
REQ-002 Parameter ALUCTL_W, default 4, width of the ALU control code (legal >= 4; codes zero-extended).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opD  in  7  decode-stage opcode.
REQ-006 funct3D  in  3  decode-stage funct3.
REQ-007 funct7b5D  in  1  decode-stage funct7 bit 5.
REQ-008 FlushE  in  1  bubble the D->E register from the hazard unit.
REQ-009 ZeroE, LtE, LtuE  in  1 each  ALU equal, signed-less-than and unsigned-less-than flags.
REQ-010 ImmSrcD  out  3  immediate format: I=000, S=001, B=010, J=011, U=100.
REQ-011 IllegalD  out  1  unrecognised opcode/funct in D.
REQ-012 PCSrcE  out  1  redirect PC (taken branch or jump).
REQ-013 JumpRegE  out  1  target is rs1+imm (jalr).
REQ-014 ALUControlE  out  ALUCTL_W  ALU operation code.
REQ-015 ALUSrcBE  out  1  ALU B operand is the immediate.
REQ-016 ResultSrcEb0  out  1  bit 0 of ResultSrc in E (load-use detection).
REQ-017 MemWriteM, RegWriteM  out  1 each  first M-slot store enable and register-write flag.
REQ-018 RegWriteW  out  1; ResultSrcW  out  2 (00 ALU, 01 memory, 10 PC+4, 11 immediate).

Function
REQ-019 D decode is combinational: R-type, I-type ALU, lw, sw, beq/bne/blt/bge/bltu/bgeu, lui; jal/jalr only under REQ-031.
REQ-020 ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9; SUB only for R-type with funct7b5=1, SRA when funct7b5=1 and funct3=101.
REQ-021 Branches use SUB; funct3 is carried to E; taken = beq ZeroE, bne !ZeroE, blt LtE, bge !LtE, bltu LtuE, bgeu !LtuE.
REQ-022 PCSrcE = (BranchE & taken) | JumpE, combinational from E registers and current flags.
REQ-023 Illegal encodings: IllegalD=1; RegWrite, MemWrite, Branch and Jump captured as 0.
REQ-024 Latency: instruction in D at cycle n -> E outputs at n+1, M outputs at n+2, W outputs at n+2+MEM_STAGES.
REQ-025 FlushE=1 at an edge loads all-zero control into E (bubble: no write, no redirect); M/W slots always advance.
REQ-026 No stall input; an E register holds exactly one cycle.

Reset
REQ-027 reset=1 at an edge clears E, all M slots and W to zero; all registered outputs read 0 in the following cycle.
REQ-028 reset and FlushE together: reset wins, identical result.
REQ-029 Reset mid-flight discards every in-flight write; decode outputs (ImmSrcD, IllegalD) remain combinational and unaffected.
REQ-030 PCSrcE=0 whenever the E register is zero, regardless of flags.

Configuration
REQ-031 Macro CU_PIPE_JUMP_EN: when defined, jal (1101111) and jalr (1100111) decode as JumpE=1 with ResultSrc=10 and RegWrite=1, and JumpRegE=1 for jalr; when undefined, both opcodes are illegal and JumpRegE is tied to 0.

Structure
REQ-032 Package cu_pipe_pkg holds the opcode constants, ALU code enum, ImmSrc and ResultSrc encodings and the E/M/W control-bundle structs.
REQ-033 Sub-module cu_decode (combinational main and ALU decoder); cu_pipe holds only the pipeline registers, the M-slot shift chain and the branch resolution.

Verification
REQ-034 reset for 2 cycles, then add (0110011, 000, 0) -> ALUControlE=0 at n+1, RegWriteM=1 at n+2, RegWriteW=1 with ResultSrcW=00 at n+3 (MEM_STAGES=1).
REQ-035 sub then sra (funct7b5=1, funct3 000 then 101) -> ALUControlE=1 then 9.
REQ-036 lw then sw -> ResultSrcEb0=1 for lw; MemWriteM=1 and RegWriteM=0 for sw; ImmSrcD=000 then 001.
REQ-037 blt with LtE=1 -> PCSrcE=1; the same with LtE=0 -> PCSrcE=0; beq with FlushE=1 -> PCSrcE=0 and no write.
REQ-038 MEM_STAGES=3, lw -> RegWriteW=1 and ResultSrcW=01 at n+5; reset asserted at n+3 -> RegWriteW never rises.
REQ-039 jalr with and without CU_JAL... no: jalr with and without CU_PIPE_JUMP_EN -> PCSrcE=JumpRegE=1 and ResultSrcW=10 when defined; IllegalD=1 and no write when undefined.
